am_mod_pipe: RTL and testbench
==============================

// Module: am_mod_pipe
// PURPOSE
//  Pipelined, parametrised AM modulator for the DDS output chain: takes offset-binary carrier and
//  modulating samples, applies run-time depth (tenths) and mode (AM / DSB-SC / CW), emits an
//  offset-binary sample. Sits between the NCO/LUT stage and the DAC formatter; valid/ready on both sides.
// PARAMETERS
//  DW      16  sample width of carrier, modulating signal and output (offset binary)
//  MAW     4   width of depth code ma (tenths; 10 = 100 %)
//  MA_MAX  15  largest accepted ma; larger writes clamp to MA_MAX (values >10 = overmodulation)
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     carrier/mod sample pair present
//  in_ready   out  1     stage can accept (transfer when in_valid & in_ready)
//  carrier    in   DW    carrier sample, offset binary
//  sig_mod    in   DW    modulating sample, offset binary
//  cfg_we     in   1     one-cycle write strobe for cfg_ma/cfg_mode
//  cfg_ma     in   MAW   depth code
//  cfg_mode   in   2     0=AM, 1=DSB-SC, 2=CW (carrier only), 3=reserved
//  cfg_err    out  1     one-cycle pulse: rejected mode write (cfg_mode==3)
//  out_valid  out  1     sig_out valid
//  out_ready  in   1     downstream accepts
//  sig_out    out  DW    modulated sample, offset binary
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, sig_out=2^(DW-1), cfg_err=0, ma_r=10, mode_r=AM, pipe valids=0.
//  Config: on cfg_we, ma_r<=min(cfg_ma,MA_MAX) next cycle; mode_r<=cfg_mode unless 3 (mode kept, ma
//   still written, cfg_err pulses). Sample accepted in the cfg_we cycle uses OLD values.
//   Each sample snapshots ma_r/mode_r at acceptance; in-flight samples never change config.
//  Pipeline: 3 stages, global enable en = !out_valid | out_ready; in_ready = en. Latency exactly 3 clk
//   from accepted input to out_valid with no stall; stalls freeze all stages, no sample lost/duplicated.
//   Bubbles (in_valid=0) propagate as invalid slots. Full throughput 1 sample/clk.
//  S1: c = signed(carrier ^ MSB), m = signed(sig_mod ^ MSB), g = ma*102 (unsigned MAW+7).
//  S2: t = (m*g) >>> 10 (arith, floor); s (signed DW+3): AM: (2^(DW-1)-1)+t; DSB: t; CW: 2^(DW-1)-1.
//  S3: p = s*c; y = p >>> (DW-1) (floor); y fitted to DW signed (see CONFIGURATION); sig_out = y ^ MSB.
//  sig_out/out_valid are registered; hold while out_valid & !out_ready.
//  Reset mid-operation: all in-flight samples discarded, config returns to reset values.
// CONFIGURATION
//  AM_MOD_SAT_EN defined: y outside [-2^(DW-1), 2^(DW-1)-1] clamps to nearest bound; extra output
//   sat_flag (1 bit) is registered alongside sig_out, high for a clamped sample.
//  Undefined: y truncated to low DW bits (two's-complement wrap), no sat_flag port.
// STRUCTURE
//  Package am_mod_pkg: mode enum (AM/DSB/CW/RSVD), DEPTH_COEF=102, DEPTH_SHIFT=10, offset-binary helpers.
//  One sub-module: am_mod_mul (registered signed multiply, parametrised widths) used in S2 and S3.
// TESTING (DW=16)
//  Reset defaults, mode AM ma=10, sig_mod=0x8000, carrier=0xFFFF -> sig_out=0xFFFE after 3 clk.
//  cfg_mode=1 (DSB), sig_mod=0x8000, any carrier -> sig_out=0x8000; cfg_mode=3 -> cfg_err pulse, mode kept.
//  ma=15, AM, sig_mod=0x0000, carrier=0xFFFF -> sig_out=0x40BF (no clamp, sat_flag=0).
//  ma=15, AM, sig_mod=0xFFFF, carrier=0x0000 -> 0x0000 with AM_MOD_SAT_EN (sat_flag=1), 0x40C3 without.
//  Stream 8 samples, out_ready low 4 clk mid-stream -> in_ready low, outputs in order, none dropped.
//  cfg_we same cycle as sample k -> k uses old ma; rst_n low with 3 in flight -> out_valid=0 at once.

Source files
------------

// File: rtl/am_mod_pkg.sv
// Shared mode encoding, depth scaling constants and offset-binary helpers for the AM modulator.
package am_mod_pkg;

  typedef enum logic [1:0] {
    ModeAm   = 2'd0,
    ModeDsb  = 2'd1,
    ModeCw   = 2'd2,
    ModeRsvd = 2'd3
  } am_mode_e;

  // Depth code is in tenths: ma * 102 / 1024 ~= ma / 10.
  localparam int unsigned DEPTH_COEF  = 102;
  localparam int unsigned DEPTH_SHIFT = 10;
  localparam int unsigned MA_RESET    = 10;

  // Offset binary and two's complement differ only in the MSB; widths up to 32 bits.
  function automatic logic [31:0] ob_flip(input logic [31:0] x, input int unsigned w);
    return x ^ (32'd1 << (w - 1));
  endfunction

  // Offset-binary code for zero (mid-scale).
  function automatic logic [31:0] ob_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/am_mod_mul.sv
// Registered signed multiplier with clock enable; product is full precision for AW x BW operands.
module am_mod_mul #(
  parameter int unsigned AW = 16,
  parameter int unsigned BW = 16,
  parameter int unsigned PW = AW + BW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic signed [AW-1:0] a_i,
  input  logic signed [BW-1:0] b_i,
  output logic signed [PW-1:0] p_o
);

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] p_d;
  logic signed [PW-1:0] p_q;

  always_comb begin
    a_ext = {{(PW - AW){a_i[AW-1]}}, a_i};
    b_ext = {{(PW - BW){b_i[BW-1]}}, b_i};
    p_d   = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/am_mod_pipe.sv
// Three-stage AM / DSB-SC / CW modulator with valid/ready handshakes on both sides.
// Define AM_MOD_SAT_EN to clamp out-of-range results and add the sat_flag output.
module am_mod_pipe
  import am_mod_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned MAW    = 4,
  parameter int unsigned MA_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  carrier,
  input  logic [DW-1:0]  sig_mod,
  input  logic           cfg_we,
  input  logic [MAW-1:0] cfg_ma,
  input  logic [1:0]     cfg_mode,
  output logic           cfg_err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  sig_out
`ifdef AM_MOD_SAT_EN
  ,
  output logic           sat_flag
`endif
);

  localparam int unsigned GW  = MAW + 7;      // depth gain ma*102
  localparam int unsigned P1W = DW + GW + 1;  // m * g, gain zero-extended to signed
  localparam int unsigned SW  = DW + 3;       // envelope s
  localparam int unsigned P2W = SW + DW;      // s * c

  localparam logic signed [P1W-1:0] FullScaleP1 = {{(P1W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
`ifdef AM_MOD_SAT_EN
  localparam logic signed [P2W-1:0] YMax = {{(P2W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [P2W-1:0] YMin = {{(P2W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
`endif

  logic en;

  // Run-time configuration
  logic [MAW-1:0] ma_q, ma_d;
  am_mode_e       mode_q, mode_d;
  logic           cfg_err_q, cfg_err_d;

  always_comb begin
    ma_d      = ma_q;
    mode_d    = mode_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      ma_d = (32'(cfg_ma) > MA_MAX) ? MAW'(MA_MAX) : cfg_ma;
      if (am_mode_e'(cfg_mode) == ModeRsvd) begin
        cfg_err_d = 1'b1;
      end else begin
        mode_d = am_mode_e'(cfg_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_q      <= MAW'(MA_RESET);
      mode_q    <= ModeAm;
      cfg_err_q <= 1'b0;
    end else begin
      ma_q      <= ma_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Stage 1: convert to signed, form depth gain from the config in force at acceptance
  logic signed [DW-1:0] c_in;
  logic signed [DW-1:0] m_in;
  logic [GW-1:0]        g_in;
  logic signed [GW:0]   g_s;

  always_comb begin
    c_in = DW'(ob_flip(32'(carrier), DW));
    m_in = DW'(ob_flip(32'(sig_mod), DW));
    g_in = GW'(ma_q) * GW'(DEPTH_COEF);
    g_s  = {1'b0, g_in};
  end

  logic signed [P1W-1:0] p1;

  am_mod_mul #(
    .AW (DW),
    .BW (GW + 1),
    .PW (P1W)
  ) u_mul_mg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .a_i   (m_in),
    .b_i   (g_s),
    .p_o   (p1)
  );

  logic                 v1_q;
  logic signed [DW-1:0] c1_q;
  am_mode_e             mode1_q;
  logic                 v2_q;
  logic                 out_valid_q;
  logic [DW-1:0]        sig_out_q;

  // Stage 2: envelope per mode
  logic signed [P1W-1:0] t_full;
  logic signed [P1W-1:0] s_full;
  logic signed [SW-1:0]  s2;
  logic                  unused_s_hi;

  always_comb begin
    t_full = p1 >>> DEPTH_SHIFT;
    case (mode1_q)
      ModeAm:  s_full = FullScaleP1 + t_full;
      ModeDsb: s_full = t_full;
      ModeCw:  s_full = FullScaleP1;
      default: s_full = '0;
    endcase
    s2 = s_full[SW-1:0];
  end

  // Envelope range is bounded by MA_MAX, so the dropped bits are pure sign extension.
  assign unused_s_hi = ^s_full[P1W-1:SW];

  logic signed [P2W-1:0] p2;

  am_mod_mul #(
    .AW (SW),
    .BW (DW),
    .PW (P2W)
  ) u_mul_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .a_i   (s2),
    .b_i   (c1_q),
    .p_o   (p2)
  );

  // Stage 3: rescale, fit to DW, back to offset binary
  logic signed [P2W-1:0] y_full;
  logic signed [DW-1:0]  y_fit;
  logic [DW-1:0]         sig_out_d;
`ifdef AM_MOD_SAT_EN
  logic sat_d;
  logic sat_q;
`else
  logic unused_y_hi;
`endif

  always_comb begin
    y_full = p2 >>> (DW - 1);
    y_fit  = y_full[DW-1:0];
`ifdef AM_MOD_SAT_EN
    sat_d = 1'b0;
    if (y_full > YMax) begin
      y_fit = YMax[DW-1:0];
      sat_d = 1'b1;
    end else if (y_full < YMin) begin
      y_fit = YMin[DW-1:0];
      sat_d = 1'b1;
    end
`endif
    sig_out_d = DW'(ob_flip(32'(y_fit), DW));
  end

`ifndef AM_MOD_SAT_EN
  // Wrap mode keeps only the low DW bits.
  assign unused_y_hi = ^y_full[P2W-1:DW];
`endif

  // A single enable freezes every stage while the output is held.
  assign en = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      c1_q        <= '0;
      mode1_q     <= ModeAm;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sig_out_q   <= DW'(ob_mid(DW));
`ifdef AM_MOD_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else if (en) begin
      v1_q        <= in_valid;
      c1_q        <= c_in;
      mode1_q     <= mode_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      sig_out_q   <= sig_out_d;
`ifdef AM_MOD_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sig_out   = sig_out_q;
  assign cfg_err   = cfg_err_q;
`ifdef AM_MOD_SAT_EN
  assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_am_mod_pipe.sv
// Scoreboard bench for am_mod_pipe (DW=16): expected samples queued at acceptance, checked on output.
module tb_am_mod_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] carrier = '0;
  logic [15:0] sig_mod = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_ma = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sig_out;
  logic        sat_flag;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int m_ma   = 10;
  int m_mode = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp_v;

  am_mod_pipe #(
    .DW     (16),
    .MAW    (4),
    .MA_MAX (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .carrier   (carrier),
    .sig_mod   (sig_mod),
    .cfg_we    (cfg_we),
    .cfg_ma    (cfg_ma),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sig_out   (sig_out)
`ifdef AM_MOD_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

`ifndef AM_MOD_SAT_EN
  assign sat_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference arithmetic on plain integers; returns {sat, sig_out}.
  function automatic logic [16:0] model(input logic [15:0] car, input logic [15:0] md,
                                        input int ma, input int mode);
    longint c, m, g, t, s, p, y;
    logic   sat;
    c = longint'(car) - 32768;
    m = longint'(md) - 32768;
    g = longint'(ma) * 102;
    t = (m * g) >>> 10;
    case (mode)
      0:       s = 32767 + t;
      1:       s = t;
      default: s = 32767;
    endcase
    p   = s * c;
    y   = p >>> 15;
    sat = 1'b0;
`ifdef AM_MOD_SAT_EN
    if (y > 32767) begin
      y = 32767;
      sat = 1'b1;
    end else if (y < -32768) begin
      y = -32768;
      sat = 1'b1;
    end
`endif
    return {sat, 16'(y + 32768)};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h required=none", sig_out);
      end else begin
        exp_v = exp_q.pop_front();
        if ({sat_flag, sig_out} !== exp_v) begin
          errors++;
          $display("FAIL sample {sat,sig_out} got=%h required=%h", {sat_flag, sig_out}, exp_v);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] car, input logic [15:0] md, input logic [16:0] ex);
    int n;
    n = 0;
    carrier  = car;
    sig_mod  = md;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready got=%b required=1", in_ready);
    end else begin
      exp_q.push_back(ex);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [15:0] car, md;
    car = 16'($urandom);
    md  = 16'($urandom);
    send(car, md, model(car, md, m_ma, m_mode));
  endtask

  task automatic write_cfg(input logic [3:0] ma, input logic [1:0] mode);
    cfg_ma   = ma;
    cfg_mode = mode;
    cfg_we   = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_ma   = (int'(ma) > 15) ? 15 : int'(ma);
    if (mode != 2'd3) m_mode = int'(mode);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b required=0", out_valid);
    end
    checks++;
    if (sig_out !== 16'h8000) begin
      errors++;
      $display("FAIL reset_sig_out got=%h required=8000", sig_out);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cfg_err got=%b required=0", cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_latency();
    carrier  = 16'hFFFF;
    sig_mod  = 16'h8000;
    in_valid = 1'b1;
    exp_q.push_back({1'b0, 16'hFFFE});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge=%0d out_valid got=%b required=0", i + 1, out_valid);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b1 || sig_out !== 16'hFFFE) begin
      errors++;
      $display("FAIL latency_3clk got valid=%b data=%h required valid=1 data=fffe",
               out_valid, sig_out);
    end
    wait_drain();
  endtask

  task automatic test_modes();
    write_cfg(4'd10, 2'd1);
    send(16'h1234, 16'h8000, {1'b0, 16'h8000});
    send(16'hF00D, 16'h8000, {1'b0, 16'h8000});
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_idle got=%b required=0", cfg_err);
    end
    write_cfg(4'd7, 2'd3);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_pulse got=%b required=1", cfg_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_one_cycle got=%b required=0", cfg_err);
    end
    // Mode stays DSB: zero modulation must still give mid-scale.
    send(16'hFFFF, 16'h8000, {1'b0, 16'h8000});
    send(16'hC000, 16'hE000, model(16'hC000, 16'hE000, 7, 1));
    repeat (2) send_rand();
    write_cfg(4'd10, 2'd2);
    send(16'hFFFF, 16'h0000, {1'b0, 16'hFFFE});
    repeat (2) send_rand();
    wait_drain();
  endtask

  task automatic test_depth();
    write_cfg(4'd15, 2'd0);
    send(16'hFFFF, 16'h0000, {1'b0, 16'h40BF});
`ifdef AM_MOD_SAT_EN
    send(16'h0000, 16'hFFFF, {1'b1, 16'h0000});
`else
    send(16'h0000, 16'hFFFF, {1'b0, 16'h40C3});
`endif
    repeat (3) send_rand();
    write_cfg(4'd3, 2'd0);
    repeat (3) send_rand();
    wait_drain();
  endtask

  task automatic test_stall_stream();
    int          base;
    logic [15:0] held;
    write_cfg(4'd6, 2'd0);
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = '0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) held = sig_out;
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready got in_ready=%b out_valid=%b required 0 1",
                     in_ready, out_valid);
          end
          if (k != 0) begin
            checks++;
            if (sig_out !== held) begin
              errors++;
              $display("FAIL stall_hold sig_out got=%h required=%h", sig_out, held);
            end
          end
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (n_out - base !== 8) begin
      errors++;
      $display("FAIL stall_count got=%0d required=8", n_out - base);
    end
  endtask

  task automatic test_cfg_same_cycle();
    write_cfg(4'd10, 2'd0);
    carrier  = 16'hFFFF;
    sig_mod  = 16'h0000;
    in_valid = 1'b1;
    cfg_ma   = 4'd3;
    cfg_mode = 2'd0;
    cfg_we   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_ready got=%b required=1", in_ready);
    end
    exp_q.push_back(model(16'hFFFF, 16'h0000, 10, 0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    m_ma     = 3;
    send(16'hFFFF, 16'h0000, model(16'hFFFF, 16'h0000, 3, 0));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    write_cfg(4'd9, 2'd0);
    for (int i = 0; i < 12; i++) begin
      send_rand();
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    write_cfg(4'd12, 2'd1);
    for (int i = 0; i < 6; i++) send_rand();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    write_cfg(4'd4, 2'd1);
    for (int i = 0; i < 3; i++) send_rand();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_valid got=%b required=1", out_valid);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || sig_out !== 16'h8000) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h required valid=0 data=8000",
               out_valid, sig_out);
    end
    m_ma   = 10;
    m_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Reset config is AM, ma=10 again.
    send(16'hFFFF, 16'h8000, {1'b0, 16'hFFFE});
    send(16'hFFFF, 16'h0000, model(16'hFFFF, 16'h0000, 10, 0));
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_depth();
    test_stall_stream();
    test_cfg_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed got=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
